// File: rtl/main_mem_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states, grant ids and
// the sizing helper for the watchdog counter.
package main_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_I_ACC = 2'd1,
    ARB_D_ACC = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // D side wins when it is the only requester, or on a tie when I had the last grant.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input arb_grant_e last);
    return d_req && (!i_req || last == GNT_I);
  endfunction

endpackage

// File: rtl/main_mem_arbiter_timeout_counter.sv
// Saturating busy-cycle counter with a sticky expiry flag; cleared per
// transaction by the arbiter, flag cleared only by RESET.
module arb_timeout_counter
  import main_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = cnt_bits(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (clr)
        count <= '0;
      else if (en && count != CNT_MAX)
        count <= count + 1'b1;
      // The flag rises on the same edge the count reaches CNT_MAX.
      if (en && count >= CNT_MAX - 1'b1)
        expired <= 1'b1;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache
// (block reads) and the D-cache (block reads and write-backs).
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int BADDR_W = 28,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [BADDR_W-1:0] I_ADDR,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [BADDR_W-1:0] D_ADDR,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [BADDR_W-1:0] MEM_ADDR,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic               ERROR
);

  arb_state_e         state, state_nxt;
  arb_grant_e         last_grant, last_grant_nxt;
  logic               launched, launched_nxt;
  logic               mem_read_nxt, mem_write_nxt;
  logic [BADDR_W-1:0] mem_addr_nxt;
  logic [BLOCK_W-1:0] mem_wdata_nxt;
  logic               i_req, d_req, done, grant, tmo_en;

  assign i_req  = I_READ;
  assign d_req  = D_READ | D_WRITE;
  // launched masks the stale MEM_BUSYWAIT seen in the cycle right after the grant.
  assign done   = launched & ~MEM_BUSYWAIT;
  assign tmo_en = (state != ARB_IDLE) & MEM_BUSYWAIT;

  assign I_BUSYWAIT = i_req & ~((state == ARB_I_ACC) & done);
  assign D_BUSYWAIT = d_req & ~((state == ARB_D_ACC) & done);
  assign I_READDATA = MEM_READDATA;
  assign D_READDATA = MEM_READDATA;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ARB_IDLE;
      last_grant    <= GNT_D;
      launched      <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      launched      <= launched_nxt;
      MEM_READ      <= mem_read_nxt;
      MEM_WRITE     <= mem_write_nxt;
      MEM_ADDR      <= mem_addr_nxt;
      MEM_WRITEDATA <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    launched_nxt   = launched;
    mem_read_nxt   = MEM_READ;
    mem_write_nxt  = MEM_WRITE;
    mem_addr_nxt   = MEM_ADDR;
    mem_wdata_nxt  = MEM_WRITEDATA;
    grant          = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant = 1'b1;
          if (pick_d(i_req, d_req, last_grant)) begin
            state_nxt      = ARB_D_ACC;
            last_grant_nxt = GNT_D;
            // A simultaneous read and write-back performs only the write.
            mem_write_nxt  = D_WRITE;
            mem_read_nxt   = ~D_WRITE;
            mem_addr_nxt   = D_ADDR;
            mem_wdata_nxt  = D_WRITEDATA;
          end else begin
            state_nxt      = ARB_I_ACC;
            last_grant_nxt = GNT_I;
            mem_read_nxt   = 1'b1;
            mem_write_nxt  = 1'b0;
            mem_addr_nxt   = I_ADDR;
          end
        end
      end
      ARB_I_ACC, ARB_D_ACC: begin
        if (done) begin
          state_nxt     = ARB_IDLE;
          launched_nxt  = 1'b0;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
        end else begin
          launched_nxt  = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .en      (tmo_en),
    .clr     (grant),
    .expired (ERROR)
  );

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Randomized and directed checks of main_mem_arbiter against a transaction-level
// reference model (owner / age / fairness bit) kept in the bench.
module tb_main_mem_arbiter;

  localparam int BLOCK_W = 128;
  localparam int BADDR_W = 28;
  localparam int TIMEOUT = 255;
  typedef logic [BLOCK_W-1:0] blk_t;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               I_READ = 1'b0, D_READ = 1'b0, D_WRITE = 1'b0, MEM_BUSYWAIT = 1'b0;
  logic [BADDR_W-1:0] I_ADDR = '0, D_ADDR = '0;
  blk_t               D_WRITEDATA = '0, MEM_READDATA = '0;
  logic               I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, ERROR;
  logic [BADDR_W-1:0] MEM_ADDR;
  blk_t               I_READDATA, D_READDATA, MEM_WRITEDATA;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner 0 = none, 1 = I-cache, 2 = D-cache.
  int                 owner = 0;
  bit                 started = 0, last_d = 1, m_rd = 0, m_wr = 0, m_err = 0;
  logic [BADDR_W-1:0] m_addr = '0;
  blk_t               m_wdata = '0;
  int                 busy_cycles = 0, lat = 0, force_lat = -1;
  bit                 use_fixed = 0, chk_en = 0, i_rel = 0, d_rel = 0;
  blk_t               fixed_rdata = '0, i_got = '0;
  int                 order[$];

  always #5 CLK = ~CLK;

  main_mem_arbiter #(.BLOCK_W(BLOCK_W), .BADDR_W(BADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .ERROR(ERROR)
  );

  task automatic check_val(input string tag, input blk_t got, input blk_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive memory, compare at negedge, advance the model, return #1 after posedge.
  task automatic step();
    bit fin;
    MEM_BUSYWAIT = (owner != 0) && (lat > 0);
    MEM_READDATA = use_fixed ? fixed_rdata : {$urandom, $urandom, $urandom, $urandom};
    @(negedge CLK);
    fin   = (owner != 0) && started && !MEM_BUSYWAIT;
    i_rel = fin && owner == 1 && I_READ;
    d_rel = fin && owner == 2 && (D_READ || D_WRITE);
    if (chk_en) begin
      check_val("mem_read", blk_t'(MEM_READ), blk_t'(m_rd));
      check_val("mem_write", blk_t'(MEM_WRITE), blk_t'(m_wr));
      check_val("mem_addr", blk_t'(MEM_ADDR), blk_t'(m_addr));
      if (m_wr) check_val("mem_wdata", MEM_WRITEDATA, m_wdata);
      check_val("i_busywait", blk_t'(I_BUSYWAIT), blk_t'(I_READ && !(owner == 1 && fin)));
      check_val("d_busywait", blk_t'(D_BUSYWAIT),
                blk_t'((D_READ || D_WRITE) && !(owner == 2 && fin)));
      check_val("error", blk_t'(ERROR), blk_t'(m_err));
      if (i_rel) check_val("i_rdata", I_READDATA, MEM_READDATA);
      if (d_rel) check_val("d_rdata", D_READDATA, MEM_READDATA);
    end
    if (i_rel) i_got = I_READDATA;

    if (RESET) begin
      owner = 0; started = 0; last_d = 1; m_rd = 0; m_wr = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; busy_cycles = 0; lat = 0;
    end else if (owner == 0) begin
      if (I_READ && (last_d || !(D_READ || D_WRITE))) begin
        owner = 1; m_rd = 1; m_wr = 0; m_addr = I_ADDR; last_d = 0;
      end else if (D_READ || D_WRITE) begin
        owner = 2; m_wr = D_WRITE; m_rd = !D_WRITE; m_addr = D_ADDR;
        m_wdata = D_WRITEDATA; last_d = 1;
      end
      if (owner != 0) begin
        busy_cycles = 0; started = 0;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
        order.push_back(owner);
      end
    end else begin
      if (MEM_BUSYWAIT) begin
        if (busy_cycles < TIMEOUT) busy_cycles++;
        if (busy_cycles == TIMEOUT) m_err = 1;
      end
      if (fin) begin
        owner = 0; started = 0; m_rd = 0; m_wr = 0;
      end else begin
        started = 1;
        if (lat > 0) lat--;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((owner != 0 || I_READ || D_READ || D_WRITE) && n < max) begin
      step();
      n++;
      if (i_rel) I_READ = 1'b0;
      if (d_rel) begin D_READ = 1'b0; D_WRITE = 1'b0; end
    end
    check_val("drain", blk_t'(owner != 0 || I_READ || D_READ || D_WRITE), '0);
  endtask

  task automatic do_reset();
    RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    force_lat = -1; use_fixed = 1'b0;
    step(); step();
    RESET = 1'b0;
  endtask

  task automatic drive_random();
    int op;
    if (!I_READ || i_rel) begin
      I_READ = ($urandom_range(0, 2) == 0);
      I_ADDR = BADDR_W'($urandom);
    end else if ($urandom_range(0, 50) == 0) begin
      I_READ = 1'b0;
    end
    if (!(D_READ || D_WRITE) || d_rel) begin
      op = int'($urandom_range(0, 9));
      D_READ      = (op <= 2) || (op == 9);
      D_WRITE     = (op >= 3 && op <= 5) || (op == 9);
      D_ADDR      = BADDR_W'($urandom);
      D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
    end else if ($urandom_range(0, 50) == 0) begin
      D_READ = 1'b0; D_WRITE = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step();
    chk_en = 1'b1;
    do_reset();
    check_val("rst_read", blk_t'(MEM_READ), '0);
    check_val("rst_write", blk_t'(MEM_WRITE), '0);
    check_val("rst_addr", blk_t'(MEM_ADDR), '0);
    check_val("rst_error", blk_t'(ERROR), '0);

    // Single I-cache read, 5 busy cycles.
    I_READ = 1'b1; I_ADDR = 28'h0000010; force_lat = 5;
    use_fixed = 1'b1; fixed_rdata = {16{8'hA5}};
    n = 0;
    while (!i_rel && n < 30) begin step(); n++; end
    I_READ = 1'b0;
    check_val("t1_release_cycle", blk_t'(n), blk_t'(7));
    check_val("t1_rdata", i_got, {16{8'hA5}});
    drain(20);

    // Simultaneous requests alternate I, D, I, D.
    do_reset();
    order.delete();
    I_READ = 1'b1; D_READ = 1'b1; I_ADDR = 28'h0000100; D_ADDR = 28'h0000200;
    n = 0;
    while (order.size() < 4 && n < 100) begin
      step(); n++;
      if (i_rel) I_ADDR = BADDR_W'($urandom);
      if (d_rel) D_ADDR = BADDR_W'($urandom);
    end
    I_READ = 1'b0; D_READ = 1'b0;
    check_val("t2_grants", blk_t'(order.size()), blk_t'(4));
    for (int k = 0; k < order.size() && k < 4; k++)
      check_val("t2_order", blk_t'(order[k]), blk_t'((k % 2 == 0) ? 1 : 2));
    drain(40);

    // Write-back then read of the same block.
    do_reset();
    D_WRITE = 1'b1; D_ADDR = 28'h00000FF; D_WRITEDATA = {8{16'h1234}};
    step();
    check_val("t3_write", blk_t'(MEM_WRITE), blk_t'(1));
    check_val("t3_read", blk_t'(MEM_READ), '0);
    check_val("t3_addr", blk_t'(MEM_ADDR), blk_t'(28'h00000FF));
    check_val("t3_wdata", MEM_WRITEDATA, {8{16'h1234}});
    n = 0;
    while (!d_rel && n < 30) begin step(); n++; end
    D_WRITE = 1'b0; D_READ = 1'b1;
    step();
    check_val("t3_rd_after_wr", blk_t'(MEM_READ), blk_t'(1));
    check_val("t3_rd_addr", blk_t'(MEM_ADDR), blk_t'(28'h00000FF));
    drain(30);

    // Illegal read+write: only the write goes out.
    D_READ = 1'b1; D_WRITE = 1'b1; D_ADDR = 28'h0ABCDEF; D_WRITEDATA = {4{32'hDEADBEEF}};
    step();
    check_val("t4_write", blk_t'(MEM_WRITE), blk_t'(1));
    check_val("t4_read", blk_t'(MEM_READ), '0);
    drain(30);

    // Memory stuck busy past the watchdog limit.
    D_READ = 1'b1; D_ADDR = 28'h0000042; force_lat = TIMEOUT + 10;
    step();
    repeat (TIMEOUT - 1) step();
    check_val("t5_err_before", blk_t'(ERROR), '0);
    step();
    check_val("t5_err_at", blk_t'(ERROR), blk_t'(1));
    drain(TIMEOUT + 40);
    check_val("t5_err_sticky", blk_t'(ERROR), blk_t'(1));

    // Reset in the middle of a D access, with I pending.
    force_lat = 20;
    D_READ = 1'b1; D_ADDR = 28'h0000077;
    repeat (3) step();
    RESET = 1'b1; I_READ = 1'b1; I_ADDR = 28'h0000033;
    step();
    check_val("t6_read", blk_t'(MEM_READ), '0);
    check_val("t6_write", blk_t'(MEM_WRITE), '0);
    check_val("t6_error", blk_t'(ERROR), '0);
    RESET = 1'b0; D_READ = 1'b0;
    step();
    check_val("t6_i_granted", blk_t'(MEM_READ), blk_t'(1));
    check_val("t6_i_addr", blk_t'(MEM_ADDR), blk_t'(28'h0000033));
    drain(40);

    // Random traffic.
    force_lat = -1; use_fixed = 1'b0;
    repeat (3000) begin
      step();
      drive_random();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
